// File: rtl/tt_sweep_ctrl.sv
// Sweep sequencer for the two-output minimization block: walks all 16 input
// codes, samples f1/f2 after a settle delay and checks them against expected masks.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] exp_f1,
    input  logic [7:0]  exp_f2,
    input  logic        f1,
    input  logic        f2,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] tt_f1,
    output logic [7:0]  tt_f2,
    output logic [4:0]  fail_cnt,
    output logic [3:0]  fail_idx
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] exp1_q, exp1_d;
    logic [7:0]  exp2_q, exp2_d;
    logic [15:0] tt1_q, tt1_d;
    logic [7:0]  tt2_q, tt2_d;
    logic [4:0]  fcnt_q, fcnt_d;
    logic [3:0]  fidx_q, fidx_d;
    logic        pass_q, pass_d;
    logic        miss1, miss2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp1_q  <= '0;
            exp2_q  <= '0;
            tt1_q   <= '0;
            tt2_q   <= '0;
            fcnt_q  <= '0;
            fidx_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
            tt1_q   <= tt1_d;
            tt2_q   <= tt2_d;
            fcnt_q  <= fcnt_d;
            fidx_q  <= fidx_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp1_d  = exp1_q;
        exp2_d  = exp2_q;
        tt1_d   = tt1_q;
        tt2_d   = tt2_q;
        fcnt_d  = fcnt_q;
        fidx_d  = fidx_q;
        pass_d  = pass_q;
        miss1   = f1 != exp1_q[idx_q];
        miss2   = !idx_q[3] && (f2 != exp2_q[idx_q[2:0]]);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    exp1_d  = exp_f1;
                    exp2_d  = exp_f2;
                    tt1_d   = '0;
                    tt2_d   = '0;
                    fcnt_d  = '0;
                    fidx_d  = '0;
                    pass_d  = 1'b0;
                    cnt_d   = SETTLE_C;
                    state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                tt1_d[idx_q] = f1;
                if (!idx_q[3]) tt2_d[idx_q[2:0]] = f2;
                fcnt_d = fcnt_q + 5'(miss1) + 5'(miss2);
                // an empty count means no mismatch has been seen yet this sweep
                if ((miss1 || miss2) && fcnt_q == 5'd0) fidx_d = idx_q;
                if (idx_q == 4'd15) begin
                    pass_d  = (fcnt_d == 5'd0);
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = SETTLE_C;
                    state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign {a, b, c, d} = idx_q;
    assign {w, x, y}    = idx_q[2:0];
    assign z            = 1'b0;
    assign busy         = state_q != S_IDLE;
    assign done         = state_q == S_DONE;
    assign pass         = pass_q;
    assign tt_f1        = tt1_q;
    assign tt_f2        = tt2_q;
    assign fail_cnt     = fcnt_q;
    assign fail_idx     = fidx_q;

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer for the two-output boolean minimization block (f1 over a,b,c,d; f2 over w,x,y). On a start request it drives all 16 input codes, waits a programmable settle time, samples f1/f2, builds the truth tables, and checks them against expected minterm masks. It sits between a test/config host and the combinational block, owning all eight of the block's inputs.

## Interface
Parameters:
- SETTLE, 1, wait cycles after each new input code before the sample cycle (range 0..15)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  sweep request, sampled in IDLE only
- exp_f1  in  16  expected f1 mask, bit i = f1 at {a,b,c,d}=i; latched on accepted start
- exp_f2  in  8  expected f2 mask, bit j = f2 at {w,x,y}=j; latched on accepted start
- f1, f2  in  1  outputs of the minimization block
- a, b, c, d, w, x, y, z  out  1  driven inputs of the minimization block
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result of last sweep, valid from done until next accepted start
- tt_f1  out  16  captured f1 truth table
- tt_f2  out  8  captured f2 truth table
- fail_cnt  out  5  number of mismatching entries (0..24)
- fail_idx  out  4  index of first mismatch in sweep order; 0 when none

## Operation
- 4-bit index idx. Drive {a,b,c,d}=idx (a MSB), {w,x,y}=idx[2:0] (w MSB), z=0. All drive outputs registered.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0. start=1 -> idx<=0, latch exp masks, clear tt_f1, tt_f2, fail_cnt, fail_idx, pass; cnt<=SETTLE; go SETTLE (SAMPLE if SETTLE=0).
- SETTLE: cnt decrements each cycle; at cnt==1 go SAMPLE.
- SAMPLE (one cycle): at its closing edge tt_f1[idx]<=f1; if idx<8, tt_f2[idx]<=f2. Compare f1 vs exp_f1[idx], and (idx<8) f2 vs exp_f2[idx]. Each mismatch increments fail_cnt (both at one idx: +2). First mismatch of the sweep sets fail_idx<=idx; later ones leave it. idx==15 -> DONE; else idx<=idx+1, cnt<=SETTLE, go SETTLE (or stay SAMPLE if SETTLE=0).
- DONE (one cycle): done=1, pass<=(fail_cnt==0) visible on the same cycle as done (computed from final count incl. last sample); go IDLE.
- For idx 8..15, f2 is not captured or checked.
- start outside IDLE is ignored; no queuing.
- tt_f1, tt_f2, fail_cnt, fail_idx, pass hold after DONE until next accepted start.

## Timing
- Reset (asynchronous, immediate): state IDLE, idx=0, a..z=0, busy=0, done=0, pass=0, tt_f1=0, tt_f2=0, fail_cnt=0, fail_idx=0.
- Start accepted on edge E: busy=1 from E; new code 0 driven from E.
- Each index occupies SETTLE+1 cycles; drive changes at the edge entering each index's first cycle.
- busy high for 16*(SETTLE+1)+1 cycles (includes DONE); done high exactly in the last of them; busy and done fall together.
- Earliest next start: the cycle after DONE (IDLE).
- Reset mid-sweep: aborts immediately, no done pulse, results cleared.

## Test plan
- Reset: assert rst with start=1 -> all outputs 0, busy stays 0 while rst high.
- Nominal, SETTLE=1, model f1=b'd', f2=w'(x'+y'), exp_f1=16'h0505, exp_f2=8'h07, one-cycle start -> busy 33 cycles, done pulse, tt_f1=16'h0505, tt_f2=8'h07, pass=1, fail_cnt=0, fail_idx=0; drive sequence 0..15 each held 2 cycles, z=0 throughout.
- Mismatch: same model, exp_f1=16'h0504, exp_f2=8'h03 -> pass=0, fail_cnt=2, fail_idx=0; exp_f1=16'h0505, exp_f2=8'h06 -> fail_cnt=1, fail_idx=0; exp_f2=8'h05 -> fail_cnt=1, fail_idx=1.
- Start during busy: pulse start at idx=5 -> ignored, sweep finishes at original time; new start after done clears tables and re-sweeps with identical results.
- Reset mid-sweep at idx=7 -> all outputs 0 same cycle, no done; subsequent start completes normally.
- SETTLE=0 -> drive code changes every cycle, busy 17 cycles, nominal results as above.
